// File: rtl/prod_to_bcd_pkg.sv
// rtl/prod_to_bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package prod_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] BLANK_CODE  = 4'hF;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/prod_to_bcd_bcd_add3.sv
// rtl/prod_to_bcd_bcd_add3.sv - one BCD digit pre-shift correction (add 3 when >= 5)
module bcd_add3
    import prod_to_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= ADD3_THRESH) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/prod_to_bcd.sv
// rtl/prod_to_bcd.sv - sequential double-dabble binary-to-BCD converter; PROD_TO_BCD_LZB_EN enables leading-zero blanking
module prod_to_bcd
    import prod_to_bcd_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic [3:0]      hund,
    output logic [3:0]      tens,
    output logic [3:0]      ones,
    output logic            busy,
    output logic            done
);

    localparam int ACC_W = DIGITS * BCD_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t               state;
    logic [IN_W-1:0]      sr;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_adj;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_W+IN_W-1:0] shifted;
    logic [3:0]           h_new;
    logic [3:0]           t_new;
    logic [3:0]           o_new;
    logic [3:0]           h_out;
    logic [3:0]           t_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[g*BCD_W +: BCD_W]),
            .dout (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    assign shifted = {acc_adj, sr} << 1;

    // Digits as they will be after the final shift, so outputs load in the same edge
    assign h_new = shifted[IN_W + 2*BCD_W +: BCD_W];
    assign t_new = shifted[IN_W + BCD_W   +: BCD_W];
    assign o_new = shifted[IN_W           +: BCD_W];

    always_comb begin
        h_out = h_new;
        t_out = t_new;
`ifdef PROD_TO_BCD_LZB_EN
        if (h_new == 4'd0) begin
            h_out = BLANK_CODE;
            if (t_new == 4'd0) begin
                t_out = BLANK_CODE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            hund  <= '0;
            tens  <= '0;
            ones  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr    <= bin;
                        acc   <= '0;
                        cnt   <= CNT_W'(IN_W);
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc <= shifted[ACC_W+IN_W-1:IN_W];
                    sr  <= shifted[IN_W-1:0];
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hund  <= h_out;
                        tens  <= t_out;
                        ones  <= o_new;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_to_bcd.sv
// tb/tb_prod_to_bcd.sv - scoreboard bench for prod_to_bcd with an arithmetic reference model
module tb_prod_to_bcd;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bin = 8'd0;
    logic [3:0] hund, tens, ones;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [11:0] exp_q[$];

    prod_to_bcd #(.IN_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .hund  (hund),
        .tens  (tens),
        .ones  (ones),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [11:0] model(input int b);
        int h, t, o;
        h = b / 100;
        t = (b / 10) % 10;
        o = b % 10;
`ifdef PROD_TO_BCD_LZB_EN
        if (h == 0) begin
            if (t == 0) t = 15;
            h = 15;
        end
`endif
        return {h[3:0], t[3:0], o[3:0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("digits", int'({hund, tens, ones}), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 0, 1);
    endtask

    task automatic run_one(input logic [7:0] b);
        int  n;
        bit  busy_ok;
        wait_idle();
        bin   = b;
        start = 1'b1;
        exp_q.push_back(model(b));
        @(posedge clk);
        #1;
        start   = 1'b0;
        bin     = 8'($urandom);
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 8);
        check("busy_during_conv", int'(busy_ok), 1);
        check("busy_in_done", int'(busy), 0);
    endtask

    initial begin
        int first_done, second_done, third_done, n;

        #2;
        check("reset_hund", int'(hund), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        #20;
        reset = 1'b1;

        run_one(8'd210);
        run_one(8'd255);
        run_one(8'd0);
        run_one(8'd9);
        run_one(8'd40);

        // Start during a running conversion must be ignored
        wait_idle();
        bin   = 8'd210;
        start = 1'b1;
        exp_q.push_back(model(210));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin   = 8'd17;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("ignored_start_drained", exp_q.size(), 0);

        // Held start retriggers every IN_W+2 cycles
        wait_idle();
        bin   = 8'd99;
        start = 1'b1;
        repeat (3) exp_q.push_back(model(99));
        first_done = 0; second_done = 0; third_done = 0; n = 0;
        while (third_done == 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                if (first_done == 0) first_done = cyc;
                else if (second_done == 0) second_done = cyc;
                else third_done = cyc;
            end
        end
        start = 1'b0;
        check("retrigger_gap1", second_done - first_done, 10);
        check("retrigger_gap2", third_done - second_done, 10);

        // Asynchronous reset mid-conversion aborts without a done pulse
        wait_idle();
        bin   = 8'd210;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_digits", int'({hund, tens, ones}), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        run_one(8'd123);

        repeat (20) run_one(8'($urandom_range(0, 255)));
        for (int i = 0; i < 256; i++) run_one(8'(i));

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prod_to_bcd.md
# prod_to_bcd

Sequential binary-to-BCD converter downstream of the 4-bit shift-add multiplier. Captures the 8-bit product when the multiplier signals completion and converts it to three BCD digits over one iteration per clock (shift-and-add-3, "double dabble"). Digits are held registered for the display/readout stage that follows.

## Interface
Parameters:
- IN_W, 8, width of binary input; must satisfy 10^DIGITS > 2^IN_W − 1
- DIGITS, 3, number of BCD output digits

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  request; sampled only in IDLE (connect to multiplier completion flag z)
- bin  in  IN_W  binary value (multiplier product y); sampled with start
- hund  out  4  BCD hundreds digit
- tens  out  4  BCD tens digit
- ones  out  4  BCD ones digit
- busy  out  1  high while a conversion is in progress
- done  out  1  single-cycle pulse: new digits valid

## Operation
- States: IDLE, CONV, DONE.
- IDLE: busy=0. If start=1 at a clock edge: load bin into shift register, clear BCD accumulator, iteration counter := IN_W, go CONV.
- CONV: each cycle, every accumulator digit ≥5 gets +3, then {accumulator, shift register} shifts left by 1; counter decrements. When counter reaches 0 after the final shift, load hund/tens/ones from accumulator, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start outside IDLE (CONV or DONE) is ignored; no queuing. A start held high continuously retriggers on every return to IDLE.
- bin changes after capture have no effect on the running conversion.
- Output digits change only on entry to DONE; they hold the last result otherwise.
- Digit values always 0–9 (hund 0–2 for IN_W=8), except blank code under Configuration.
- Reset values: hund=tens=ones=0, busy=0, done=0, state IDLE, counter 0.
- reset asserted mid-conversion: abort immediately, all outputs return to reset values; no done pulse.

## Timing
- Start sampled at edge k → busy=1 from edge k through edge k+IN_W.
- Final iteration at edge k+IN_W; digits updated and done=1 from edge k+IN_W to k+IN_W+1 (busy=0 during DONE).
- Earliest next accepted start: edge k+IN_W+2 (IDLE re-entered at k+IN_W+1, start sampled on following edge... i.e. start sampled at the first edge in IDLE).
- Total start-to-done latency: IN_W cycles (8 for default); throughput one conversion per IN_W+2 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- PROD_TO_BCD_LZB_EN defined: leading-zero blanking. On loading outputs, hund=4'hF if zero; tens=4'hF if hund and tens both zero. ones never blanked. Reset values unchanged (0).
- Undefined: digits output exactly as computed, including leading zeros.

## Structure
- Package prod_to_bcd_pkg: state enum (IDLE, CONV, DONE), BCD_W=4, BLANK_CODE=4'hF, ADD3_THRESH=5.
- One sub-module: bcd_add3 — combinational, 4-bit digit in, digit+3 if ≥5 else unchanged; instantiated DIGITS times.

## Test plan
- bin=8'd210 (14×15), start pulse one cycle → done exactly 8 cycles after sampling edge; hund=2, tens=1, ones=0; busy high for the 8 intervening cycles.
- bin=8'd255 → 2,5,5; bin=8'd0 → 0,0,0 (with PROD_TO_BCD_LZB_EN: F,F,0); bin=8'd9 → 0,0,9 (LZB: F,F,9); bin=8'd40 → 0,4,0 (LZB: F,4,0).
- Start=1 with bin=8'd17 at cycle 3 of a conversion of 8'd210 → ignored; result 2,1,0; single done pulse.
- start held high, bin=8'd99 constant → repeated done pulses every 10 cycles, digits 0,9,9 each time.
- reset driven low at cycle 4 of a conversion (asynchronously, between edges) → busy, done, digits go 0 immediately; no done pulse after release; next start converts normally.
- Exhaustive sweep bin=0..255 back-to-back → every result matches bin/100, (bin/10)%10, bin%10.
